mantissa_sub48_pipe: RTL and testbench

//  Pipelined 48-bit mantissa subtractor, the subtract-side counterpart of the 48-bit carry-select mantissa adder.

---
 rtl/mantissa_sub48_pipe.sv | 189 ++++++++++++++++++
 tb/tb_mantissa_sub48_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_sub48_pipe.sv
// 2-stage pipelined 48-bit |a-b| with sign, unified or split (28b hi / 20b lo) lanes.
// Optional leading-zero counts on the result when MANT_SUB_LZC_EN is defined.
module mantissa_sub48_pipe #(
  parameter int W_HI = 28,
  parameter int W_LO = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] a,
  input  logic [47:0] b,
  input  logic        ct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] diff,
  output logic        sign_hi,
  output logic        sign_lo,
  output logic        ct_out,
  output logic [4:0]  lz_hi,
  output logic [4:0]  lz_lo
);

  localparam int W = W_HI + W_LO;

  logic         adv;
  logic [W_LO:0] sum_lo;
  logic [W_HI:0] sum_hi;
  logic          cin_hi;

  logic         s1_valid_d, s1_valid_q;
  logic [W-1:0] s1_raw_d, s1_raw_q;
  logic         s1_neg_hi_d, s1_neg_hi_q;
  logic         s1_neg_lo_d, s1_neg_lo_q;
  logic         s1_ct_d, s1_ct_q;

  logic         s2_valid_d, s2_valid_q;
  logic [W-1:0] diff_d, diff_q;
  logic         sign_hi_d, sign_hi_q;
  logic         sign_lo_d, sign_lo_q;
  logic         ct_out_d, ct_out_q;
  logic [W-1:0] mag;

  assign adv      = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || adv;

  // a + ~b + 1 per lane; in split mode the hi lane gets its own carry-in.
  always_comb begin
    sum_lo = {1'b0, a[W_LO-1:0]} + {1'b0, ~b[W_LO-1:0]} + {{W_LO{1'b0}}, 1'b1};
    cin_hi = ct ? 1'b1 : sum_lo[W_LO];
    sum_hi = {1'b0, a[W-1:W_LO]} + {1'b0, ~b[W-1:W_LO]} + {{W_HI{1'b0}}, cin_hi};
  end

  always_comb begin
    mag = s1_raw_q;
    if (s1_ct_q) begin
      mag[W-1:W_LO] = s1_neg_hi_q ? -s1_raw_q[W-1:W_LO] : s1_raw_q[W-1:W_LO];
      mag[W_LO-1:0] = s1_neg_lo_q ? -s1_raw_q[W_LO-1:0] : s1_raw_q[W_LO-1:0];
    end else if (s1_neg_hi_q) begin
      mag = -s1_raw_q;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_raw_d    = s1_raw_q;
    s1_neg_hi_d = s1_neg_hi_q;
    s1_neg_lo_d = s1_neg_lo_q;
    s1_ct_d     = s1_ct_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      s1_raw_d    = {sum_hi[W_HI-1:0], sum_lo[W_LO-1:0]};
      s1_neg_hi_d = ~sum_hi[W_HI];
      s1_neg_lo_d = ct & ~sum_lo[W_LO];
      s1_ct_d     = ct;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    sign_hi_d  = sign_hi_q;
    sign_lo_d  = sign_lo_q;
    ct_out_d   = ct_out_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (adv && s1_valid_q) begin
      diff_d    = mag;
      sign_hi_d = s1_neg_hi_q;
      sign_lo_d = s1_neg_lo_q;
      ct_out_d  = s1_ct_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_raw_q    <= '0;
      s1_neg_hi_q <= 1'b0;
      s1_neg_lo_q <= 1'b0;
      s1_ct_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      diff_q      <= '0;
      sign_hi_q   <= 1'b0;
      sign_lo_q   <= 1'b0;
      ct_out_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_raw_q    <= s1_raw_d;
      s1_neg_hi_q <= s1_neg_hi_d;
      s1_neg_lo_q <= s1_neg_lo_d;
      s1_ct_q     <= s1_ct_d;
      s2_valid_q  <= s2_valid_d;
      diff_q      <= diff_d;
      sign_hi_q   <= sign_hi_d;
      sign_lo_q   <= sign_lo_d;
      ct_out_q    <= ct_out_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign sign_hi   = sign_hi_q;
  assign sign_lo   = sign_lo_q;
  assign ct_out    = ct_out_q;

`ifdef MANT_SUB_LZC_EN
  logic [4:0] lz_hi_d, lz_hi_q;
  logic [4:0] lz_lo_d, lz_lo_q;

  // Both lanes always counted; unified consumers chain lz_lo when lz_hi is full width.
  function automatic logic [4:0] lzc_hi(input logic [W_HI-1:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = W_HI - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [4:0] lzc_lo(input logic [W_LO-1:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = W_LO - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  always_comb begin
    lz_hi_d = lz_hi_q;
    lz_lo_d = lz_lo_q;
    if (adv && s1_valid_q) begin
      lz_hi_d = lzc_hi(mag[W-1:W_LO]);
      lz_lo_d = lzc_lo(mag[W_LO-1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lz_hi_q <= 5'd0;
      lz_lo_q <= 5'd0;
    end else begin
      lz_hi_q <= lz_hi_d;
      lz_lo_q <= lz_lo_d;
    end
  end

  assign lz_hi = lz_hi_q;
  assign lz_lo = lz_lo_q;
`else
  assign lz_hi = 5'd0;
  assign lz_lo = 5'd0;
`endif

endmodule

// File: tb/tb_mantissa_sub48_pipe.sv
// Bench for mantissa_sub48_pipe: directed cases plus randomized traffic against a queue-based model.
module tb_mantissa_sub48_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] a = '0;
  logic [47:0] b = '0;
  logic        ct = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] diff;
  logic        sign_hi, sign_lo, ct_out;
  logic [4:0]  lz_hi, lz_lo;

  int total = 0;
  int bad = 0;
  int n_out = 0;
  int stall_cnt = 0;
  logic acc = 1'b0;
  logic [9:0] last_lz;
  logic [60:0] exp_q[$];

  mantissa_sub48_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ct(ct), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .sign_hi(sign_hi), .sign_lo(sign_lo), .ct_out(ct_out),
    .lz_hi(lz_hi), .lz_lo(lz_lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] lzn(input logic [47:0] v, input int w);
    int n;
    n = w;
    for (int i = 0; i < w; i++) if (v[i]) n = w - 1 - i;
    return 5'(n);
  endfunction

  // Expected {diff, sign_hi, sign_lo, ct, lz_hi, lz_lo} from plain magnitude arithmetic.
  function automatic logic [60:0] model(input logic [47:0] ma, input logic [47:0] mb, input logic mct);
    logic [47:0] d;
    logic [27:0] ah, bh;
    logic [19:0] al, bl;
    logic sh, sl;
    logic [4:0] zh, zl;
    ah = ma[47:20]; bh = mb[47:20];
    al = ma[19:0];  bl = mb[19:0];
    if (!mct) begin
      sh = ma < mb;
      sl = 1'b0;
      d  = sh ? mb - ma : ma - mb;
    end else begin
      sh = ah < bh;
      sl = al < bl;
      d  = {sh ? bh - ah : ah - bh, sl ? bl - al : al - bl};
    end
`ifdef MANT_SUB_LZC_EN
    zh = lzn({20'd0, d[47:20]}, 28);
    zl = lzn({28'd0, d[19:0]}, 20);
`else
    zh = 5'd0;
    zl = 5'd0;
`endif
    return {d, sh, sl, mct, zh, zl};
  endfunction

  always @(posedge rst) exp_q.delete();

  // Compare process: sampled on the falling edge, every cycle the output is valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          chk("stream", 64'({diff, sign_hi, sign_lo, ct_out, lz_hi, lz_lo}), 64'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && !in_ready) stall_cnt++;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, ct));
      acc = in_valid && in_ready;
    end else begin
      acc = 1'b0;
    end
  end

  task automatic run_one(input string nm, input logic [47:0] ta, input logic [47:0] tb_v,
                         input logic tct, input logic [47:0] ed, input logic esh, input logic esl);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb_v; ct = tct; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd2);
    chk({nm, "_diff"}, 64'(diff), 64'(ed));
    chk({nm, "_sign_hi"}, 64'(sign_hi), 64'(esh));
    chk({nm, "_sign_lo"}, 64'(sign_lo), 64'(esl));
    last_lz = {lz_hi, lz_lo};
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int idx, cyc, out0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_data", 64'({diff, sign_hi, sign_lo, ct_out, lz_hi, lz_lo}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_one("t1", 48'h000000000005, 48'h000000000003, 1'b0, 48'h000000000002, 1'b0, 1'b0);
    run_one("t2", 48'h000000100000, 48'h000000000001, 1'b0, 48'h0000000FFFFF, 1'b0, 1'b0);
    run_one("t2_swap", 48'h000000000001, 48'h000000100000, 1'b0, 48'h0000000FFFFF, 1'b1, 1'b0);
    run_one("t3_split", {28'h0000001, 20'h00000}, {28'h0000000, 20'h00001}, 1'b1,
            {28'h0000001, 20'h00001}, 1'b0, 1'b1);
    run_one("t5_equal", 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0, 48'h0, 1'b0, 1'b0);
`ifdef MANT_SUB_LZC_EN
    chk("t5_equal_lz", 64'(last_lz), 64'({5'd28, 5'd20}));
`else
    chk("t5_equal_lz", 64'(last_lz), 64'd0);
`endif
    run_one("t5_extreme", 48'h0, 48'hFFFFFFFFFFFF, 1'b0, 48'hFFFFFFFFFFFF, 1'b1, 1'b0);
    chk("t5_extreme_lz", 64'(last_lz), 64'd0);

    // Back-pressure: 8 back-to-back beats with out_ready low for cycles 3..7.
    stall_cnt = 0;
    out0 = n_out;
    idx = 0;
    cyc = 0;
    a = {16'($urandom()), $urandom()}; b = {16'($urandom()), $urandom()};
    ct = 1'($urandom_range(0, 1)); in_valid = 1'b1; out_ready = 1'b1;
    while (idx < 8 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 8) begin
          a = {16'($urandom()), $urandom()}; b = {16'($urandom()), $urandom()};
          ct = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = !(cyc >= 3 && cyc <= 7);
    end
    chk("t4_all_accepted", 64'(idx), 64'd8);
    drain("t4_drain");
    chk("t4_stall_seen", 64'(stall_cnt > 0), 64'd1);
    chk("t4_out_count", 64'(n_out - out0), 64'd8);

    // Reset with both stages occupied.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    a = 48'h123456789ABC; b = 48'h0000FFFF0000; ct = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      a = a + 48'd7;
    end
    chk("t6_full_stall", 64'(in_ready), 64'd0);
    @(negedge clk); #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t6_out_valid_async", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6_in_ready_after", 64'(in_ready), 64'd1);
    chk("t6_out_valid_after", 64'(out_valid), 64'd0);
    run_one("t6_post", 48'h000000000010, 48'h000000000020, 1'b0, 48'h000000000010, 1'b1, 1'b0);

    // Randomized traffic with random stalls and mode changes.
    in_valid = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = {16'($urandom()), $urandom()};
        b = {16'($urandom()), $urandom()};
        case ($urandom_range(0, 7))
          0: b = a;
          1: b[19:0] = a[19:0];
          2: b[47:20] = a[47:20];
          default: ;
        endcase
        ct = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
